// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM encoding and round/schedule logic functions.
package sha256_pkg;

  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StRound = 2'd1;
  localparam state_t StDone  = 2'd2;

  localparam logic [31:0] RoundK [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Initial hash value H0..H7
  localparam logic [31:0] InitHash [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// 16-word sliding message schedule; w_t is always the current round's W[t].
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [511:0] block_in,
  output logic [31:0]  w_t
);

  logic [31:0] win_q [16];
  logic [31:0] w_next;

  // W[t+16] from the current window
  always_comb begin
    w_next = small_sigma1(win_q[14]) + win_q[9] + small_sigma0(win_q[1]) + win_q[0];
  end

  // Load the block on start, otherwise slide one word per round
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) win_q[i] <= block_in[511 - 32 * i -: 32];
    end else if (shift) begin
      for (int i = 0; i < 15; i++) win_q[i] <= win_q[i + 1];
      win_q[15] <= w_next;
    end
  end

  assign w_t = win_q[0];

endmodule

// File: rtl/sha256_compress.sv
// Iterative SHA-256 compression: one round per clock, final a..h presented for
// the downstream chaining-word accumulators (no H += addition here).
module sha256_compress
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic [255:0] h_in,
  output logic         busy,
  output logic         done,
  output logic [5:0]   round,
  output logic [255:0] state_out,
  output logic [31:0]  e_out
);

  localparam logic [5:0] LastRound = 6'(ROUNDS - 1);

  state_t      state_q, state_d;
  logic [5:0]  round_q;
  logic        done_q;
  logic [31:0] a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
  logic [31:0] w_t, t1, t2;
  logic        load, shift;

  assign load  = (state_q == StIdle) && start;
  assign shift = (state_q == StRound);

  sha256_msg_sched u_msg_sched (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .shift    (shift),
    .block_in (block_in),
    .w_t      (w_t)
  );

  // Round temporaries for the current round index
  always_comb begin
    t1 = h_q + big_sigma1(e_q) + ch(e_q, f_q, g_q) + RoundK[round_q] + w_t;
    t2 = big_sigma0(a_q) + maj(a_q, b_q, c_q);
  end

  // FSM next state; start only matters in idle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRound;
      StRound: if (round_q == LastRound) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, round counter and working variables
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      round_q <= '0;
      done_q  <= 1'b0;
      {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= '0;
    end else begin
      state_q <= state_d;
      // done is registered out of DONE: it pulses the cycle after DONE, with a..h already final
      done_q  <= (state_q == StDone);
      if (load) begin
        round_q <= '0;
        {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= h_in;
      end else if (shift) begin
        // Explicit wrap so a shortened ROUNDS still reads 0 after the run
        round_q <= (round_q == LastRound) ? '0 : round_q + 6'd1;
        h_q <= g_q;
        g_q <= f_q;
        f_q <= e_q;
        e_q <= d_q + t1;
        d_q <= c_q;
        c_q <= b_q;
        b_q <= a_q;
        a_q <= t1 + t2;
      end
    end
  end

  assign busy      = (state_q == StRound) || (state_q == StDone);
  assign done      = done_q;
  assign round     = round_q;
  assign state_out = {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q};
  assign e_out     = e_q;

endmodule
